// File: rtl/xy_idx_seq_pkg.sv
// Shared definitions for the x/y index raster-scan sequencer.
// State encoding and default geometry.
package xy_idx_seq_pkg;

  localparam int unsigned IDX_W_DEF  = 6;
  localparam int unsigned ADDR_W_DEF = 12;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CLR  = 2'd1;
  localparam logic [1:0] ST_REQ  = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CLR  = ST_CLR,
    S_REQ  = ST_REQ,
    S_FIN  = ST_FIN
  } state_e;

endpackage

// File: rtl/xy_idx_seq.sv
// Raster-scan sequencer driving the external x/y index registers.
// It walks x fastest and y slowest, and keeps a running linear element address.
module xy_idx_seq
  import xy_idx_seq_pkg::*;
#(
  parameter int unsigned IDX_W  = IDX_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [IDX_W-1:0]  size_x_i,
  input  logic [IDX_W-1:0]  size_y_i,
  input  logic [IDX_W-1:0]  x_ind_i,
  input  logic [IDX_W-1:0]  y_ind_i,
  input  logic              ack_i,
  output logic [IDX_W-1:0]  x_ind_nxt_o,
  output logic              x_ind_en_o,
  output logic              x_ind_clr_o,
  output logic [IDX_W-1:0]  y_ind_nxt_o,
  output logic              y_ind_en_o,
  output logic              y_ind_clr_o,
  output logic              req_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              busy_o,
  output logic              done_o
);

  state_e              state_r, state_nxt_s;
  logic [IDX_W-1:0]    sx_r, sy_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                latch_s, addr_clr_s, addr_inc_s;
  logic                x_last_s, y_last_s;

  // Terminal-index tests; sizes are nonzero whenever these are used.
  assign x_last_s = (x_ind_i == (sx_r - IDX_W'(1)));
  assign y_last_s = (y_ind_i == (sy_r - IDX_W'(1)));
  assign addr_o   = addr_r;

  // State, latched sizes and address counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= S_IDLE;
      sx_r    <= {IDX_W{1'b0}};
      sy_r    <= {IDX_W{1'b0}};
      addr_r  <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (latch_s) begin
        sx_r <= size_x_i;
        sy_r <= size_y_i;
      end
      if (addr_clr_s) begin
        addr_r <= {ADDR_W{1'b0}};
      end else if (addr_inc_s) begin
        addr_r <= addr_r + ADDR_W'(1);
      end
    end
  end

  // Next-state and register controls; abort wins over ack, and req drops with abort.
  always_comb begin
    state_nxt_s = state_r;
    latch_s     = 1'b0;
    addr_clr_s  = 1'b0;
    addr_inc_s  = 1'b0;
    x_ind_nxt_o = {IDX_W{1'b0}};
    x_ind_en_o  = 1'b0;
    x_ind_clr_o = 1'b0;
    y_ind_nxt_o = {IDX_W{1'b0}};
    y_ind_en_o  = 1'b0;
    y_ind_clr_o = 1'b0;
    req_o       = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start_i && (size_x_i != {IDX_W{1'b0}}) && (size_y_i != {IDX_W{1'b0}})) begin
          latch_s     = 1'b1;
          state_nxt_s = S_CLR;
        end else if (start_i) begin
          state_nxt_s = S_FIN;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_CLR: begin
        busy_o      = 1'b1;
        x_ind_clr_o = 1'b1;
        y_ind_clr_o = 1'b1;
        addr_clr_s  = 1'b1;
        if (abort_i) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_REQ;
        end
      end
      S_REQ: begin
        busy_o = 1'b1;
        if (abort_i) begin
          x_ind_clr_o = 1'b1;
          y_ind_clr_o = 1'b1;
          state_nxt_s = S_IDLE;
        end else begin
          req_o = 1'b1;
          if (ack_i && !x_last_s) begin
            x_ind_en_o  = 1'b1;
            x_ind_nxt_o = x_ind_i + IDX_W'(1);
            addr_inc_s  = 1'b1;
          end else if (ack_i && !y_last_s) begin
            x_ind_clr_o = 1'b1;
            y_ind_en_o  = 1'b1;
            y_ind_nxt_o = y_ind_i + IDX_W'(1);
            addr_inc_s  = 1'b1;
          end else if (ack_i) begin
            state_nxt_s = S_FIN;
          end else begin
            state_nxt_s = S_REQ;
          end
        end
      end
      S_FIN: begin
        done_o      = 1'b1;
        x_ind_clr_o = 1'b1;
        y_ind_clr_o = 1'b1;
        state_nxt_s = S_IDLE;
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_xy_idx_seq.sv
// Directed self-checking bench for xy_idx_seq with the two index registers in the loop.
module tb_xy_idx_seq;
  localparam int IDX_W  = 6;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start_i = 1'b0, abort_i = 1'b0, ack_i = 1'b0;
  logic [IDX_W-1:0]  size_x_i = '0, size_y_i = '0;
  logic [IDX_W-1:0]  x_reg, y_reg, x_nxt, y_nxt;
  logic              x_en, x_clr, y_en, y_clr, req, busy, done;
  logic [ADDR_W-1:0] addr;
  int                pass_cnt = 0;
  int                total_cnt = 0;

  always #5 clk = ~clk;

  xy_idx_seq #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .abort_i(abort_i),
    .size_x_i(size_x_i), .size_y_i(size_y_i), .x_ind_i(x_reg), .y_ind_i(y_reg),
    .ack_i(ack_i), .x_ind_nxt_o(x_nxt), .x_ind_en_o(x_en), .x_ind_clr_o(x_clr),
    .y_ind_nxt_o(y_nxt), .y_ind_en_o(y_en), .y_ind_clr_o(y_clr), .req_o(req),
    .addr_o(addr), .busy_o(busy), .done_o(done)
  );

  // Index registers of the datapath, sharing rstn with the sequencer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_reg <= '0;
      y_reg <= '0;
    end else begin
      if (x_clr) x_reg <= '0;
      else if (x_en) x_reg <= x_nxt;
      if (y_clr) y_reg <= '0;
      else if (y_en) y_reg <= y_nxt;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    #3;
    total_cnt++;
    if ({x_nxt, x_en, x_clr, y_nxt, y_en, y_clr, req, addr, busy, done} !== '0)
      $display("FAIL reset_outputs got=%h want=0",
               {x_nxt, x_en, x_clr, y_nxt, y_en, y_clr, req, addr, busy, done});
    else pass_cnt++;
    cyc();
    rstn = 1'b1;
    cyc();
  endtask

  task automatic test_scan_3x2();
    int ex, ey;
    start_i = 1'b1; size_x_i = 6'd3; size_y_i = 6'd2;
    cyc();
    start_i = 1'b0; ack_i = 1'b1;
    #1;
    total_cnt++;
    if ({busy, x_clr, y_clr, req} !== 4'b1110)
      $display("FAIL s32_clr got=%b want=1110", {busy, x_clr, y_clr, req});
    else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      cyc();
      ex = k % 3; ey = k / 3;
      total_cnt++;
      if ({req, busy, x_reg, y_reg, addr} !== {1'b1, 1'b1, 6'(ex), 6'(ey), 12'(k)})
        $display("FAIL s32_elem k=%0d got req=%b x=%0d y=%0d addr=%0d want x=%0d y=%0d addr=%0d",
                 k, req, x_reg, y_reg, addr, ex, ey, k);
      else pass_cnt++;
      total_cnt++;
      if (ex < 2) begin
        if ({x_en, x_clr, y_en, x_nxt} !== {3'b100, 6'(ex + 1)})
          $display("FAIL s32_xadv k=%0d got en=%b clr=%b yen=%b nxt=%0d", k, x_en, x_clr, y_en, x_nxt);
        else pass_cnt++;
      end else if (ey == 0) begin
        if ({x_en, x_clr, y_en, y_nxt} !== {3'b011, 6'd1})
          $display("FAIL s32_yadv k=%0d got xen=%b xclr=%b yen=%b ynxt=%0d", k, x_en, x_clr, y_en, y_nxt);
        else pass_cnt++;
      end else begin
        if ({x_en, y_en, done} !== 3'b000)
          $display("FAIL s32_last got xen=%b yen=%b done=%b want 000", x_en, y_en, done);
        else pass_cnt++;
      end
    end
    cyc();
    ack_i = 1'b0;
    #1;
    total_cnt++;
    if ({done, busy, req, x_clr, y_clr, addr} !== {5'b10011, 12'd5})
      $display("FAIL s32_done got done=%b busy=%b req=%b addr=%0d want done=1 busy=0 addr=5",
               done, busy, req, addr);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if ({done, busy} !== 2'b00) $display("FAIL s32_after got done=%b busy=%b want 00", done, busy);
    else pass_cnt++;
  endtask

  task automatic test_slow_4x1();
    int acks = 0, ex = 0;
    start_i = 1'b1; size_x_i = 6'd4; size_y_i = 6'd1;
    cyc();
    start_i = 1'b0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      ack_i = (c % 3 == 2);
      #1;
      total_cnt++;
      if ({req, x_reg, y_en, y_reg} !== {1'b1, 6'(ex), 1'b0, 6'd0})
        $display("FAIL slow_elem c=%0d got req=%b x=%0d yen=%b y=%0d want x=%0d",
                 c, req, x_reg, y_en, y_reg, ex);
      else pass_cnt++;
      total_cnt++;
      if (x_en !== (ack_i && ex < 3))
        $display("FAIL slow_xen c=%0d got=%b want=%b", c, x_en, (ack_i && ex < 3));
      else pass_cnt++;
      if (ack_i) begin acks++; ex++; end
    end
    cyc();
    ack_i = 1'b0;
    #1;
    total_cnt++;
    if ({done, acks} !== {1'b1, 32'd4}) $display("FAIL slow_done got done=%b acks=%0d want 1/4", done, acks);
    else pass_cnt++;
    cyc();
  endtask

  task automatic test_zero_size();
    int dones = 0, bad = 0;
    start_i = 1'b1; size_x_i = 6'd0; size_y_i = 6'd5;
    cyc();
    start_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (done) dones++;
      if (req || busy || x_en || y_en || (x_clr && !done)) bad++;
      cyc();
    end
    total_cnt++;
    if ({dones, bad} !== {32'd1, 32'd0})
      $display("FAIL zero_size got dones=%0d bad_cycles=%0d want 1/0", dones, bad);
    else pass_cnt++;
  endtask

  task automatic test_1x63();
    start_i = 1'b1; size_x_i = 6'd1; size_y_i = 6'd63;
    cyc();
    start_i = 1'b0; ack_i = 1'b1;
    for (int k = 0; k < 63; k++) begin
      cyc();
      total_cnt++;
      if ({req, x_reg, y_reg, addr} !== {1'b1, 6'd0, 6'(k), 12'(k)})
        $display("FAIL c1_elem k=%0d got req=%b x=%0d y=%0d addr=%0d", k, req, x_reg, y_reg, addr);
      else pass_cnt++;
      total_cnt++;
      if (k < 62) begin
        if ({x_en, x_clr, y_en, y_nxt} !== {3'b011, 6'(k + 1)})
          $display("FAIL c1_adv k=%0d got xen=%b xclr=%b yen=%b ynxt=%0d", k, x_en, x_clr, y_en, y_nxt);
        else pass_cnt++;
      end else begin
        if ({x_en, y_en} !== 2'b00) $display("FAIL c1_last got xen=%b yen=%b want 00", x_en, y_en);
        else pass_cnt++;
      end
    end
    cyc();
    ack_i = 1'b0;
    #1;
    total_cnt++;
    if ({done, addr} !== {1'b1, 12'd62}) $display("FAIL c1_done got done=%b addr=%0d want 1/62", done, addr);
    else pass_cnt++;
    cyc();
  endtask

  task automatic test_abort();
    int dones = 0;
    start_i = 1'b1; size_x_i = 6'd4; size_y_i = 6'd4;
    cyc();
    start_i = 1'b0; ack_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      start_i = (k == 1);
      size_x_i = 6'd2;
      if (k == 5) abort_i = 1'b1;
      #1;
      total_cnt++;
      if ({x_reg, y_reg} !== {6'(k % 4), 6'(k / 4)})
        $display("FAIL abort_elem k=%0d got x=%0d y=%0d want x=%0d y=%0d", k, x_reg, y_reg, k % 4, k / 4);
      else pass_cnt++;
    end
    start_i = 1'b0;
    total_cnt++;
    if ({req, x_clr, y_clr, x_en, y_en} !== 5'b01100)
      $display("FAIL abort_cycle got req=%b xclr=%b yclr=%b xen=%b yen=%b want 01100",
               req, x_clr, y_clr, x_en, y_en);
    else pass_cnt++;
    cyc();
    abort_i = 1'b0; ack_i = 1'b0;
    #1;
    total_cnt++;
    if ({busy, req, x_reg, y_reg} !== {2'b00, 6'd0, 6'd0})
      $display("FAIL abort_idle got busy=%b req=%b x=%0d y=%0d want 0/0/0/0", busy, req, x_reg, y_reg);
    else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      if (done) dones++;
      cyc();
    end
    total_cnt++;
    if (dones !== 0) $display("FAIL abort_nodone got dones=%0d want 0", dones);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int acks = 0, got_done = 0;
    start_i = 1'b1; size_x_i = 6'd3; size_y_i = 6'd3;
    cyc();
    start_i = 1'b0; ack_i = 1'b1;
    cyc(); cyc(); cyc();
    rstn = 1'b0;
    #1;
    total_cnt++;
    if ({x_nxt, x_en, x_clr, y_nxt, y_en, y_clr, req, addr, busy, done, x_reg, y_reg} !== '0)
      $display("FAIL rst_mid got req=%b busy=%b addr=%0d x=%0d y=%0d want all 0", req, busy, addr, x_reg, y_reg);
    else pass_cnt++;
    ack_i = 1'b0;
    cyc();
    rstn = 1'b1;
    cyc();
    start_i = 1'b1; size_x_i = 6'd2; size_y_i = 6'd2;
    cyc();
    start_i = 1'b0; ack_i = 1'b1;
    for (int c = 0; c < 20 && got_done == 0; c++) begin
      cyc();
      if (done) got_done = 1;
      else if (req && ack_i) acks++;
    end
    ack_i = 1'b0;
    total_cnt++;
    if ({got_done, acks} !== {32'd1, 32'd4})
      $display("FAIL rst_restart got done_seen=%0d acks=%0d want 1/4", got_done, acks);
    else pass_cnt++;
    cyc();
  endtask

  initial begin
    test_reset();
    test_scan_3x2();
    test_slow_4x1();
    test_zero_size();
    test_1x63();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
